// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and frame/timing helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned START_BITS = 1;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned BIT_IDX_W  = 3;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Bits per frame, start bit through last stop bit.
  function automatic int unsigned frame_bits(input int unsigned parity_en,
                                              input int unsigned stop_bits);
    return START_BITS + DATA_BITS + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period timer; bit_done marks the last clock of each bit period.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);

  localparam int unsigned          CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_done_q, bit_done_d;

  // bit_done_q tracks cnt_q == CNT_LAST without a combinational output path.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
    bit_done_d = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      bit_done_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bit_done_q <= bit_done_d;
    end
  end

  assign bit_done = bit_done_q;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: fetches bytes from a normal-mode FIFO and serialises them
// as start / 8 data LSB-first / optional parity / 1-2 stop bits on uart_txd.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tf_empty,
  input  logic [DATA_BITS-1:0] tf_data,
  output logic                 tf_rdreq,
  output logic                 uart_txd,
  output logic                 busy
);

  localparam int unsigned          CLKS_PER_BIT  = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT      = BIT_IDX_W'(DATA_BITS - 1);
  localparam logic                 PAR_INV       = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  localparam logic                 STOP_IDX_LAST = (STOP_BITS == 2);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_engine: CLK_FREQ/BAUD must be at least 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_tx_engine: STOP_BITS must be 1 or 2");
  end

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic                 parity_q, parity_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 txd_q, txd_d;
  logic                 rdreq_q, rdreq_d;
  logic                 busy_q, busy_d;
  logic                 timer_restart_c;
  logic                 bit_done;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .restart  (timer_restart_c),
    .bit_done (bit_done)
  );

  // Next-state, datapath updates and next-cycle output values.
  always_comb begin
    state_d         = state_q;
    shift_d         = shift_q;
    bit_idx_d       = bit_idx_q;
    parity_d        = parity_q;
    stop_idx_d      = stop_idx_q;
    timer_restart_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!tf_empty) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d         = tf_data;
        parity_d        = (^tf_data) ^ PAR_INV;
        bit_idx_d       = '0;
        stop_idx_d      = 1'b0;
        timer_restart_c = 1'b1;
        state_d         = ST_START;
      end
      ST_START: begin
        if (bit_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) state_d = ST_STOP;
      end
      ST_STOP: begin
        // tf_empty is only looked at on the final stop clock.
        if (bit_done) begin
          if (stop_idx_q == STOP_IDX_LAST) begin
            state_d = tf_empty ? ST_IDLE : ST_FETCH;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rdreq_d = (state_d == ST_FETCH);
    busy_d  = (state_d != ST_IDLE);
    txd_d   = 1'b1;
    unique case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
      ST_PARITY: txd_d = parity_d;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      parity_q   <= 1'b0;
      stop_idx_q <= 1'b0;
      txd_q      <= 1'b1;
      rdreq_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      parity_q   <= parity_d;
      stop_idx_q <= stop_idx_d;
      txd_q      <= txd_d;
      rdreq_q    <= rdreq_d;
      busy_q     <= busy_d;
    end
  end

  assign uart_txd = txd_q;
  assign tf_rdreq = rdreq_q;
  assign busy     = busy_q;

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Single-clock UART transmit engine that drains bytes from a normal-mode (non-show-ahead) transmit FIFO read port and serialises them onto `uart_txd`. It generates its own bit timing from the system clock, so it needs no separate divided UART clock. It supports optional even/odd parity and 1 or 2 stop bits. It is the transmit-direction counterpart of the UART receive path and sits between the transmit FIFO and the TXD pin.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115_200: line rate in bit/s. `CLKS_PER_BIT = CLK_FREQ/BAUD`, integer division, truncated.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. **One clock; reset is synchronous and active-high.**
- `tf_empty`  in  1  FIFO read-side empty flag.
- `tf_data`  in  8  FIFO `q`. Valid the cycle after `tf_rdreq`.
- `tf_rdreq`  out  1  FIFO read strobe, one-cycle pulse.
- `uart_txd`  out  1  serial line, idle high.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- **IDLE**
  - `uart_txd`=1.
  - If `tf_empty`=0, go to FETCH.
- **FETCH**
  - `tf_rdreq`=1 for exactly this cycle.
  - Unconditionally go to LOAD.
- **LOAD**
  - Capture `tf_data` into the shift register.
  - Compute parity: XOR of the 8 bits, inverted if `PARITY_ODD`.
  - Clear the bit counter. Go to START.
- **START**
  - `uart_txd`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA**
  - Send 8 bits, LSB first, `CLKS_PER_BIT` cycles each.
  - Bit index runs 0..7.
  - After bit 7, go to PARITY if `PARITY_EN`, else STOP.
- **PARITY**
  - Drive the parity bit for `CLKS_PER_BIT` cycles, then go to STOP.
- **STOP**
  - `uart_txd`=1 for `STOP_BITS*CLKS_PER_BIT` cycles.
  - On the last cycle: go to FETCH if `tf_empty`=0, else IDLE.
- `tf_empty` is sampled only in IDLE and on the last STOP cycle. It is never sampled mid-frame.
- The bit timer counts 0..`CLKS_PER_BIT`-1 and reloads to 0 on every bit boundary and on entry to START.
- Reset behaviour:
  - Reset values: state IDLE, `uart_txd`=1, `tf_rdreq`=0, `busy`=0, counters 0.
  - Reset mid-frame aborts the frame. Line returns high the cycle after reset is sampled.
  - The fetched byte is discarded.
  - Reset asserted during FETCH still leaves the FIFO read completed; that byte is lost by design.
- Elaboration rules:
  - `CLKS_PER_BIT` < 2 is an elaboration error.
  - `STOP_BITS` outside {1,2} is an elaboration error.

## Timing
- Outputs `uart_txd`, `tf_rdreq` and `busy` are registered. There are no combinational paths from inputs to outputs.
- Latency from idle: with IDLE sampling `tf_empty`=0 at edge k:
  - `tf_rdreq` is high in cycle k+1.
  - LOAD is cycle k+2.
  - Start bit (`uart_txd` falling) begins cycle k+3.
- Frame length: `(1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT` cycles, counted from the start-bit falling edge to the end of the last stop bit.
- Back-to-back frames: exactly 2 extra idle-high cycles (FETCH, LOAD) between the end of a stop bit and the next start bit.
- Baud error comes from truncation only. No fractional accumulation.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding (7 states, 3 bits);
  - parity-mode constants;
  - the `clks_per_bit(CLK_FREQ, BAUD)` function;
  - frame-length helper constants.
  
  The receive path reuses the same package.
- One natural sub-module: `uart_bit_timer`.
  - Parameter: `CLKS_PER_BIT`.
  - Inputs: `clk`, `rst`, `restart`.
  - Output: `bit_done` pulse.
- The FSM, shift register, bit index and parity logic stay in `uart_tx_engine`.

## Test plan
All scenarios use `CLK_FREQ`=16, `BAUD`=1, so `CLKS_PER_BIT`=16.
- **Single byte:** FIFO model holds 0xA5 (`tf_empty` drops at cycle 10), no parity, 1 stop bit.
  - `tf_rdreq` pulses once at cycle 11.
  - Start bit falls at cycle 13.
  - Line reads 0,1,0,1,0,0,1,0,1,1, 16 cycles per bit.
  - `busy` falls at cycle 173.
- **Back-to-back:** FIFO holds 0x00 then 0xFF.
  - Second `tf_rdreq` occurs on the cycle after the last stop cycle.
  - Second start bit begins exactly 2 cycles after the first stop bit ends.
  - Exactly 2 `tf_rdreq` pulses in total.
- **Parity:** `PARITY_EN`=1.
  - 0x07 with `PARITY_ODD`=0 gives parity bit 1.
  - 0x07 with `PARITY_ODD`=1 gives parity bit 0.
  - 0x03 with `PARITY_ODD`=0 gives parity bit 0.
  - Frame length is 176 cycles.
- **Two stop bits:** `STOP_BITS`=2, byte 0x55.
  - Stop phase is high for 32 cycles.
  - The next frame's FETCH happens no earlier than the end of cycle 32 of the stop phase.
- **Reset mid-frame:** assert `rst` for 1 cycle during DATA bit 3.
  - Next cycle: `uart_txd`=1, `busy`=0, `tf_rdreq`=0.
  - A new byte 0x3C then transmits correctly from a clean start bit.
- **Empty FIFO:** hold `tf_empty`=1 for 500 cycles.
  - `tf_rdreq` stays 0, `uart_txd` stays 1, `busy` stays 0 throughout.
